// File: rtl/if_id_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_id_pkg
// Brief   : Shared state encoding, NOP default and counter helper for IF/ID.
// Rev     : 1.0
// ============================================================================
package if_id_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

   // True while a counter of the given width has not yet reached all-ones.
   function automatic logic cnt_can_inc(input logic [31:0] value, input int unsigned width);
      logic [32:0] limit;
      limit = (33'd1 << width) - 33'd1;
      return {1'b0, value} != limit;
   endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_entry.sv
`default_nettype none
// ============================================================================
// Module  : if_id_entry
// Brief   : pc + instruction holding register with load and synchronous clear.
// Rev     : 1.0
// ============================================================================
module if_id_entry
   import if_id_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [ADDR_W-1:0] pc_d,
   input  logic [INST_W-1:0] inst_d,
   output logic [ADDR_W-1:0] pc_q,
   output logic [INST_W-1:0] inst_q
);

   // Clear wins over load so a flush can never let a new entry slip in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q   <= '0;
         inst_q <= NOP_INST;
      end else if (clear) begin
         pc_q   <= '0;
         inst_q <= NOP_INST;
      end else if (load) begin
         pc_q   <= pc_d;
         inst_q <= inst_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/if_id_skid_stage.sv
`default_nettype none
// ============================================================================
// Module  : if_id_skid_stage
// Brief   : IF->ID boundary with 2-entry skid buffer, flush and stat counters.
// Rev     : 1.0
// ============================================================================
module if_id_skid_stage
   import if_id_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter int                CNT_W    = 16,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic [INST_W-1:0] instruction_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] pc_out,
   output logic [INST_W-1:0] instruction_out,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  flush_count,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   state_t            r_state;
   state_t            w_state_next;
   logic              w_accept;
   logic              w_pop;
   logic              w_head_load;
   logic              w_head_from_skid;
   logic              w_head_clear;
   logic              w_skid_load;
   logic              w_skid_clear;
   logic [ADDR_W-1:0] w_head_pc_d;
   logic [INST_W-1:0] w_head_inst_d;
   logic [ADDR_W-1:0] w_skid_pc;
   logic [INST_W-1:0] w_skid_inst;
   logic [CNT_W-1:0]  r_flush_cnt;
   logic [CNT_W-1:0]  r_stall_cnt;

   // Handshake flags come from the state register alone.
   assign in_ready  = (r_state != ST_FULL);
   assign out_valid = (r_state != ST_EMPTY);
   assign occupancy = r_state;
   assign w_accept  = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_EMPTY;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next     = r_state;
      w_head_load      = 1'b0;
      w_head_from_skid = 1'b0;
      w_head_clear     = 1'b0;
      w_skid_load      = 1'b0;
      w_skid_clear     = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_next = ST_ONE;
               w_head_load  = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_accept && w_pop) begin
               w_head_load  = 1'b1;
            end else if (w_accept) begin
               w_state_next = ST_FULL;
               w_skid_load  = 1'b1;
            end else if (w_pop) begin
               w_state_next = ST_EMPTY;
               w_head_clear = 1'b1;
            end
         end
         ST_FULL: begin
            if (w_pop) begin
               w_state_next     = ST_ONE;
               w_head_load      = 1'b1;
               w_head_from_skid = 1'b1;
               w_skid_clear     = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_EMPTY;
            w_head_clear = 1'b1;
            w_skid_clear = 1'b1;
         end
      endcase
      if (flush) begin
         w_state_next = ST_EMPTY;
         w_head_load  = 1'b0;
         w_skid_load  = 1'b0;
         w_head_clear = 1'b1;
         w_skid_clear = 1'b1;
      end
   end

   assign w_head_pc_d   = w_head_from_skid ? w_skid_pc   : pc_in;
   assign w_head_inst_d = w_head_from_skid ? w_skid_inst : instruction_in;

   if_id_entry #(
      .ADDR_W   (ADDR_W),
      .INST_W   (INST_W),
      .NOP_INST (NOP_INST)
   ) u_head (
      .clk    (clk),
      .rst    (rst),
      .load   (w_head_load),
      .clear  (w_head_clear),
      .pc_d   (w_head_pc_d),
      .inst_d (w_head_inst_d),
      .pc_q   (pc_out),
      .inst_q (instruction_out)
   );

   if_id_entry #(
      .ADDR_W   (ADDR_W),
      .INST_W   (INST_W),
      .NOP_INST (NOP_INST)
   ) u_skid (
      .clk    (clk),
      .rst    (rst),
      .load   (w_skid_load),
      .clear  (w_skid_clear),
      .pc_d   (pc_in),
      .inst_d (instruction_in),
      .pc_q   (w_skid_pc),
      .inst_q (w_skid_inst)
   );

   // Stall qualifier uses the pre-flush handshake, so a flush cycle can count too.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_flush_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (flush && cnt_can_inc(32'(r_flush_cnt), CNT_W))
            r_flush_cnt <= r_flush_cnt + c_cnt_one;
         if (out_valid && !out_ready && cnt_can_inc(32'(r_stall_cnt), CNT_W))
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
      end
   end

   assign flush_count = r_flush_cnt;
   assign stall_count = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_id_skid_stage
// Brief   : Self-checking bench for if_id_skid_stage against a queue model.
// Rev     : 1.0
// ============================================================================
module tb_if_id_skid_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] pc_in = '0;
   logic [31:0] instruction_in = '0;

   logic        in_ready, out_valid;
   logic [31:0] pc_out, instruction_out;
   logic [1:0]  occupancy;
   logic [15:0] flush_count, stall_count;

   logic        in_ready4, out_valid4;
   logic [31:0] pc_out4, instruction_out4;
   logic [1:0]  occupancy4;
   logic [3:0]  flush_count4, stall_count4;

   always #5 clk = ~clk;

   if_id_skid_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .pc_in(pc_in), .instruction_in(instruction_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .pc_out(pc_out), .instruction_out(instruction_out),
      .occupancy(occupancy), .flush_count(flush_count), .stall_count(stall_count)
   );

   if_id_skid_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready4),
      .pc_in(pc_in), .instruction_in(instruction_in),
      .out_valid(out_valid4), .out_ready(out_ready),
      .pc_out(pc_out4), .instruction_out(instruction_out4),
      .occupancy(occupancy4), .flush_count(flush_count4), .stall_count(stall_count4)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: ordered list of held entries plus plain counters.
   logic [31:0] m_pc[$];
   logic [31:0] m_inst[$];
   int m_flush, m_stall, m_flush4, m_stall4;

   function automatic void model_reset();
      m_pc.delete();
      m_inst.delete();
      m_flush = 0; m_stall = 0; m_flush4 = 0; m_stall4 = 0;
   endfunction

   function automatic void model_step(input logic f, input logic iv, input logic orr,
                                      input logic [31:0] pc, input logic [31:0] inst);
      int n;
      n = m_pc.size();
      if (n > 0 && !orr) begin
         if (m_stall < 65535) m_stall++;
         if (m_stall4 < 15) m_stall4++;
      end
      if (f) begin
         if (m_flush < 65535) m_flush++;
         if (m_flush4 < 15) m_flush4++;
         m_pc.delete();
         m_inst.delete();
      end else begin
         if (n > 0 && orr) begin
            void'(m_pc.pop_front());
            void'(m_inst.pop_front());
         end
         if (iv && n < 2) begin
            m_pc.push_back(pc);
            m_inst.push_back(inst);
         end
      end
   endfunction

   function automatic logic [175:0] dut_vec();
      return {out_valid, in_ready, occupancy, pc_out, instruction_out,
              flush_count, stall_count, flush_count4, stall_count4,
              out_valid4, in_ready4, occupancy4, pc_out4, instruction_out4};
   endfunction

   function automatic logic [175:0] exp_vec();
      logic        v;
      logic [1:0]  occ;
      logic [31:0] hp, hi;
      v   = (m_pc.size() > 0);
      occ = 2'(m_pc.size());
      hp  = v ? m_pc[0]   : 32'h0;
      hi  = v ? m_inst[0] : 32'h0;
      return {v, (occ != 2'd2), occ, hp, hi,
              16'(m_flush), 16'(m_stall), 4'(m_flush4), 4'(m_stall4),
              v, (occ != 2'd2), occ, hp, hi};
   endfunction

   task automatic drive(input logic f, input logic iv, input logic orr, input logic [31:0] pc);
      flush          = f;
      in_valid       = iv;
      out_ready      = orr;
      pc_in          = pc;
      instruction_in = $urandom;
   endtask

   task automatic step();
      @(posedge clk);
      model_step(flush, in_valid, out_ready, pc_in, instruction_in);
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      #1;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL reset_held got=%h exp=%h", dut_vec(), exp_vec());
      end
      @(posedge clk); #1;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL reset_release got=%h exp=%h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_streaming();
      for (int k = 1; k <= 3; k++) begin
         drive(1'b0, 1'b1, 1'b1, 32'(4 * k));
         step();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL stream k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
         end
      end
      drive(1'b0, 1'b0, 1'b1, 32'h0);
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL stream_drain got=%h exp=%h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_skid();
      for (int k = 0; k < 8; k++) begin
         if (k < 2)      drive(1'b0, 1'b1, 1'b0, 32'(4 * (k + 1)));
         else if (k < 5) drive(1'b0, 1'b1, 1'b0, 32'd12);
         else            drive(1'b0, 1'b0, 1'b1, 32'h0);
         step();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL skid k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_flush_full();
      drive(1'b0, 1'b1, 1'b0, 32'h40); step();
      drive(1'b0, 1'b1, 1'b0, 32'h44); step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL flush_fill got=%h exp=%h", dut_vec(), exp_vec());
      end
      drive(1'b1, 1'b1, 1'b0, 32'h20);
      step();
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (dut_vec() !== exp_vec() || (out_valid && pc_out === 32'h20)) begin
            n_err++;
            $display("FAIL flush_full k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
         end
         drive(1'b0, 1'b0, 1'b1, 32'h0);
         step();
      end
   endtask

   task automatic test_flush_pop();
      drive(1'b0, 1'b1, 1'b1, 32'h50); step();
      drive(1'b1, 1'b0, 1'b1, 32'h0);  step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL flush_pop got=%h exp=%h", dut_vec(), exp_vec());
      end
      drive(1'b0, 1'b0, 1'b1, 32'h0); step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL flush_pop_after got=%h exp=%h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_saturation();
      drive(1'b0, 1'b1, 1'b0, 32'h60); step();
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0);
         step();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL sat k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
         end
      end
      n_cmp++;
      if (stall_count4 !== 4'd15) begin
         n_err++;
         $display("FAIL sat_stall4 got=%0d exp=15", stall_count4);
      end
      drive(1'b0, 1'b0, 1'b1, 32'h0); step();
   endtask

   task automatic test_async_reset();
      drive(1'b0, 1'b1, 1'b0, 32'h70); step();
      drive(1'b0, 1'b1, 1'b0, 32'h74); step();
      n_cmp++;
      if (occupancy !== 2'd2) begin
         n_err++;
         $display("FAIL areset_fill got=%0d exp=2", occupancy);
      end
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL areset_immediate got=%h exp=%h", dut_vec(), exp_vec());
      end
      @(posedge clk); #1;
      rst = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 32'h80);
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL areset_restart got=%h exp=%h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         drive(($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 70),
               ($urandom_range(0, 99) < 60), $urandom);
         step();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_skid();
      test_flush_full();
      test_flush_pop();
      test_saturation();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
- Pipeline boundary between the instruction-fetch stage and the decode stage.
- Captures the fetch output (PC+4 and instruction word) and presents it to decode through a valid/ready handshake.
- A 2-entry skid buffer lets fetch run at full throughput while decode stalls; a branch flush squashes all held entries.
- Includes saturating flush and stall counters for lab performance reporting.

Parameters:
ADDR_W, 32, width of the pc bus
INST_W, 32, width of the instruction word
CNT_W, 16, width of the flush/stall statistic counters
NOP_INST, 0, instruction value presented when no valid entry is held

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
flush  input  1  branch-taken squash from execute; synchronous
in_valid  input  1  fetch presents a valid pc/instruction
in_ready  output  1  stage can accept an entry this cycle
pc_in  input  ADDR_W  PC+4 from fetch
instruction_in  input  INST_W  instruction word from fetch
out_valid  output  1  decode-side entry valid
out_ready  input  1  decode accepts this cycle (the inverse of the hazard-unit freeze)
pc_out  output  ADDR_W  head entry pc
instruction_out  output  INST_W  head entry instruction
occupancy  output  2  number of held entries, 0..2
flush_count  output  CNT_W  number of cycles in which flush was asserted, saturating
stall_count  output  CNT_W  number of cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (rst=0, asynchronous): state EMPTY; out_valid=0; in_ready=1; pc_out=0; instruction_out=NOP_INST; occupancy=0; both counters=0; skid register cleared.
- Storage: head register drives the outputs directly; skid register holds a second entry. There is no combinational path from in_* to out_*.
- in_ready is 1 in every state except FULL, decoded from the state register only, so it has no combinational dependence on out_ready.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Latency: an entry accepted in cycle N appears on the outputs in cycle N+1. Throughput is 1 per cycle while out_ready=1.
- State transitions, evaluated when flush=0:
  EMPTY: on accept, go to ONE and load the head from the inputs.
  ONE: accept & pop, stay in ONE and load the head from the inputs. Accept & !pop, go to FULL and load the skid from the inputs. !accept & pop, go to EMPTY. Otherwise hold.
  FULL: on pop, go to ONE and load the head from the skid. Otherwise hold. No input is accepted in FULL.
- Data hold: while out_valid=1 and out_ready=0, pc_out and instruction_out are stable.
- Bubble: whenever out_valid=0, pc_out=0 and instruction_out=NOP_INST. The head is cleared on every transition into EMPTY.
- Flush (highest priority):
  - Next state is EMPTY regardless of accept or pop; the input offered in that cycle is discarded.
  - Head and skid are cleared; flush_count increments.
  - in_ready remains combinational from the state only, so it may read 1 during a flush cycle; the entry is still dropped.
- Counters:
  - Each increments by 1 per qualifying cycle and saturates at all-ones; there is no wrap.
  - Flush-cycle stall: stall_count evaluates the pre-flush out_valid/out_ready values.
  - Both counters are cleared only by reset.
- occupancy encodes the state: EMPTY=0, ONE=1, FULL=2. The value 3 never occurs.
- Reset asserted mid-operation drops all entries immediately and asynchronously. Behaviour after rst deasserts is identical to power-up.

Decomposition:
- Shared package if_id_pkg:
  - State encoding constants: ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - NOP_INST default value.
  - Counter saturation helper.
- Sub-module if_id_entry: a parameterised pc+instruction register with load and synchronous clear inputs, asynchronous active-low reset. It is instantiated twice, once for the head and once for the skid.
- The FSM and the counters live in the top level.

Test Plan:
- Reset check: rst=0 mid-stream with occupancy=2 -> outputs immediately show out_valid=0, pc_out=0, instruction_out=0, occupancy=0, in_ready=1.
- Streaming: in_valid=1 with pc_in=4,8,12, out_ready=1 -> pc_out=4,8,12 on consecutive cycles, each one cycle after input, occupancy stays 1.
- Skid: feed pc 4,8 with out_ready=0 -> occupancy=2, in_ready=0, pc_out holds 4, stall_count increments each cycle. Release out_ready -> pc_out 4 then 8, no entry lost or duplicated.
- Flush while FULL with in_valid=1, pc_in=0x20 -> next cycle out_valid=0, occupancy=0, instruction_out=NOP_INST, flush_count=1, pc 0x20 never appears.
- Saturation: set CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_count reaches 15 and stays at 15.
- Flush and pop in the same cycle at occupancy=1 -> EMPTY next cycle and flush_count increments. The popped entry is counted as consumed by decode once only.
